// File: rtl/axi_chk_pkg.sv
// rtl/axi_chk_pkg.sv - error codes and width helpers shared by the AXI burst checker
// No ports: provides err_code_e (bit index into err_vec), ERR_W and len_w().
package axi_chk_pkg;

    typedef enum logic [2:0] {
        ERR_NONE    = 3'd0,
        ERR_W_LEN   = 3'd1,
        ERR_W_NO_AW = 3'd2,
        ERR_B_EARLY = 3'd3,
        ERR_R_LEN   = 3'd4,
        ERR_R_NO_AR = 3'd5,
        ERR_OVF     = 3'd6,
        ERR_BAD_ID  = 3'd7
    } err_code_e;

    localparam int ERR_W = 8;

    // Burst lengths are stored as AxLEN+1, so one extra bit holds 2**LSIZE beats.
    function automatic int len_w(input int lsize);
        return lsize + 1;
    endfunction

endpackage

// File: rtl/axi_len_fifo.sv
// rtl/axi_len_fifo.sv - burst length FIFO with empty-FIFO head bypass
// Ports: clk, rst_n (async active-low), clr (sync clear), push/push_data (ignored when full),
//        pop, head (push_data when empty), full, empty, count.
module axi_len_fifo #(
    parameter int W     = 9,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [W-1:0]             head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    // A pop on an empty FIFO consumes the same-cycle push; both pointers
    // advance together and the count stays at zero.
    assign do_pop  = pop && (!empty || do_push);
    assign head    = empty ? push_data : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/axi_burst_checker.sv
// rtl/axi_burst_checker.sv - passive AXI4 burst length and handshake ordering checker
// Ports: axi_aclk, axi_aresetn (async active-low); AW/W/B/AR/R valid, ready, id, len, last taps;
//        clr (sync clear); err_vec, first_err, err_cnt, wr/rd beat and burst counters, wr_pending.
module axi_burst_checker #(
    parameter int IDSIZE      = 4,
    parameter int LSIZE       = 8,
    parameter int ID_NUM      = 4,
    parameter int OUTSTANDING = 4,
    parameter int CNT_W       = 32
) (
    input  logic                           axi_aclk,
    input  logic                           axi_aresetn,
    input  logic                           axi_awvalid,
    input  logic                           axi_awready,
    input  logic [IDSIZE-1:0]              axi_awid,
    input  logic [LSIZE-1:0]               axi_awlen,
    input  logic                           axi_wvalid,
    input  logic                           axi_wready,
    input  logic                           axi_wlast,
    input  logic                           axi_bvalid,
    input  logic                           axi_bready,
    input  logic                           axi_arvalid,
    input  logic                           axi_arready,
    input  logic [IDSIZE-1:0]              axi_arid,
    input  logic [LSIZE-1:0]               axi_arlen,
    input  logic                           axi_rvalid,
    input  logic                           axi_rready,
    input  logic                           axi_rlast,
    input  logic [IDSIZE-1:0]              axi_rid,
    input  logic                           clr,
    output logic [7:0]                     err_vec,
    output logic [2:0]                     first_err,
    output logic [15:0]                    err_cnt,
    output logic [CNT_W-1:0]               wr_beats,
    output logic [CNT_W-1:0]               rd_beats,
    output logic [CNT_W-1:0]               wr_bursts,
    output logic [CNT_W-1:0]               rd_bursts,
    output logic [$clog2(OUTSTANDING):0]   wr_pending
);

    import axi_chk_pkg::*;

    localparam int LW  = len_w(LSIZE);
    localparam int IXW = (ID_NUM > 1) ? $clog2(ID_NUM) : 1;
    localparam int PW  = $clog2(OUTSTANDING) + 1;
    localparam int BPW = $clog2(2 * OUTSTANDING) + 1;
    localparam logic [BPW-1:0] BP_MAX = BPW'(2 * OUTSTANDING);
    localparam logic [BPW-1:0] BP_ONE = BPW'(1);

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
    assign aw_hs = axi_awvalid && axi_awready;
    assign w_hs  = axi_wvalid  && axi_wready;
    assign b_hs  = axi_bvalid  && axi_bready;
    assign ar_hs = axi_arvalid && axi_arready;
    assign r_hs  = axi_rvalid  && axi_rready;

    // ---------------- write side ----------------
    logic [LW-1:0]  awlen_ext, wf_head, wbeat, wbeat_nxt;
    logic           wf_full, wf_empty, wf_avail, w_exp_last, w_close;
    logic [BPW-1:0] bpend, bpend_nxt;

    assign awlen_ext = LW'(axi_awlen) + LW'(1);

    axi_len_fifo #(.W(LW), .DEPTH(OUTSTANDING)) u_wr_fifo (
        .clk(axi_aclk), .rst_n(axi_aresetn), .clr(clr),
        .push(aw_hs), .push_data(awlen_ext), .pop(w_close),
        .head(wf_head), .full(wf_full), .empty(wf_empty), .count(wr_pending)
    );

    // An AW into an empty FIFO is never blocked, so it always provides a head.
    assign wf_avail   = !wf_empty || aw_hs;
    assign wbeat_nxt  = wbeat + LW'(1);
    assign w_exp_last = (wbeat_nxt == wf_head);
    assign w_close    = w_hs && wf_avail && (axi_wlast || w_exp_last);

    always_comb begin
        bpend_nxt = bpend;
        if (w_close && bpend != BP_MAX) bpend_nxt = bpend_nxt + BP_ONE;
        if (b_hs && bpend != '0)        bpend_nxt = bpend_nxt - BP_ONE;
    end

    // ---------------- read side ----------------
    logic [LW-1:0]     arlen_ext, r_head, rbeat_nxt;
    logic [LW-1:0]     rf_head [ID_NUM];
    logic [LW-1:0]     rbeat   [ID_NUM];
    logic [PW-1:0]     rf_count [ID_NUM];
    logic [ID_NUM-1:0] rf_full, rf_empty, ar_push, r_pop, unused_cnt;
    logic [IXW-1:0]    ar_idx, r_idx;
    logic              ar_ok, r_ok, r_avail, r_exp_last, r_close;
    logic              unused_id;

    assign arlen_ext  = LW'(axi_arlen) + LW'(1);
    assign ar_ok      = {1'b0, axi_arid} < (IDSIZE + 1)'(ID_NUM);
    assign r_ok       = {1'b0, axi_rid}  < (IDSIZE + 1)'(ID_NUM);
    assign ar_idx     = axi_arid[IXW-1:0];
    assign r_idx      = axi_rid[IXW-1:0];
    assign r_head     = rf_head[r_idx];
    assign r_avail    = !rf_empty[r_idx] || ar_push[r_idx];
    assign rbeat_nxt  = rbeat[r_idx] + LW'(1);
    assign r_exp_last = (rbeat_nxt == r_head);
    assign r_close    = r_hs && r_ok && r_avail && (axi_rlast || r_exp_last);
    assign unused_id  = ^axi_awid;

    for (genvar g = 0; g < ID_NUM; g++) begin : g_rd
        assign ar_push[g] = ar_hs && ar_ok && (ar_idx == IXW'(g));
        assign r_pop[g]   = r_close && (r_idx == IXW'(g));
        axi_len_fifo #(.W(LW), .DEPTH(OUTSTANDING)) u_rd_fifo (
            .clk(axi_aclk), .rst_n(axi_aresetn), .clr(clr),
            .push(ar_push[g]), .push_data(arlen_ext), .pop(r_pop[g]),
            .head(rf_head[g]), .full(rf_full[g]), .empty(rf_empty[g]), .count(rf_count[g])
        );
        assign unused_cnt[g] = ^rf_count[g];
    end

    // ---------------- error collection ----------------
    logic [ERR_W-1:0] errs;
    logic [3:0]       n_err;
    logic [2:0]       lowest;
    logic [16:0]      cnt_sum;

    always_comb begin
        errs               = '0;
        errs[ERR_W_LEN]    = w_close && (axi_wlast != w_exp_last);
        errs[ERR_W_NO_AW]  = w_hs && !wf_avail;
        errs[ERR_B_EARLY]  = b_hs && (bpend == '0);
        errs[ERR_R_LEN]    = r_close && (axi_rlast != r_exp_last);
        errs[ERR_R_NO_AR]  = r_hs && r_ok && !r_avail;
        errs[ERR_OVF]      = (aw_hs && wf_full) || (ar_hs && ar_ok && rf_full[ar_idx]);
        errs[ERR_BAD_ID]   = (ar_hs && !ar_ok) || (r_hs && !r_ok);
        n_err  = '0;
        lowest = '0;
        // Walk downward so the last hit is the lowest code.
        for (int k = ERR_W - 1; k >= 1; k--) begin
            if (errs[k]) begin
                n_err  = n_err + 4'd1;
                lowest = 3'(k);
            end
        end
        cnt_sum = {1'b0, err_cnt} + 17'(n_err);
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            err_vec   <= '0;
            first_err <= '0;
            err_cnt   <= '0;
            wr_beats  <= '0;
            rd_beats  <= '0;
            wr_bursts <= '0;
            rd_bursts <= '0;
            wbeat     <= '0;
            bpend     <= '0;
            for (int i = 0; i < ID_NUM; i++) rbeat[i] <= '0;
        end else if (clr) begin
            err_vec   <= '0;
            first_err <= '0;
            err_cnt   <= '0;
            wr_beats  <= '0;
            rd_beats  <= '0;
            wr_bursts <= '0;
            rd_bursts <= '0;
            wbeat     <= '0;
            bpend     <= '0;
            for (int i = 0; i < ID_NUM; i++) rbeat[i] <= '0;
        end else begin
            err_vec <= err_vec | errs;
            if (err_vec == '0 && errs != '0) first_err <= lowest;
            err_cnt <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
            bpend   <= bpend_nxt;
            if (w_hs)              wr_beats  <= wr_beats + CNT_W'(1);
            if (w_close)           wr_bursts <= wr_bursts + CNT_W'(1);
            if (w_hs && wf_avail)  wbeat     <= w_close ? '0 : wbeat_nxt;
            if (r_hs)              rd_beats  <= rd_beats + CNT_W'(1);
            if (r_close)           rd_bursts <= rd_bursts + CNT_W'(1);
            if (r_hs && r_ok && r_avail) rbeat[r_idx] <= r_close ? '0 : rbeat_nxt;
        end
    end

endmodule

// File: doc/axi_burst_checker.md
Name: axi_burst_checker

Overview:
- Synthesizable passive AXI4 observer, successor to the testbench mirror. Taps every channel of one AXI link; it never drives a handshake.
- Tracks outstanding bursts: writes in order, reads per ID across ID_NUM IDs.
- Checks beat count against AxLEN and handshake ordering. Exports sticky error flags, first-error code and traffic counters.
- Used in simulation benches and on FPGA debug builds.

Parameters:
IDSIZE, 4, width of awid/arid/rid/bid
LSIZE, 8, width of awlen/arlen
ID_NUM, 4, read IDs tracked (0..ID_NUM-1), power of 2, at most 2**IDSIZE
OUTSTANDING, 4, depth of each length FIFO, power of 2, at least 2
CNT_W, 32, width of traffic counters

Ports:
axi_aclk  in  1  clock
axi_aresetn  in  1  asynchronous active-low reset
axi_awvalid, axi_awready  in  1  AW handshake
axi_awid  in  IDSIZE  write ID (not checked)
axi_awlen  in  LSIZE  write burst length minus 1
axi_wvalid, axi_wready, axi_wlast  in  1  W channel
axi_bvalid, axi_bready  in  1  B handshake
axi_arvalid, axi_arready  in  1  AR handshake
axi_arid  in  IDSIZE  read ID
axi_arlen  in  LSIZE  read burst length minus 1
axi_rvalid, axi_rready, axi_rlast  in  1  R channel
axi_rid  in  IDSIZE  read data ID
clr  in  1  synchronous clear of errors and counters
err_vec  out  8  sticky error flags, bit = axi_chk_pkg code
first_err  out  3  code of the first error since reset/clr
err_cnt  out  16  saturating count of error events
wr_beats, rd_beats  out  CNT_W  handshaked W/R beats, wrapping
wr_bursts, rd_bursts  out  CNT_W  completed bursts, wrapping
wr_pending  out  $clog2(OUTSTANDING)+1  queued AW entries

Behaviour:
- Reset: all outputs 0, all FIFOs empty, beat counters 0. clr has the same effect synchronously and wins over any same-cycle event.
- Handshake = valid&&ready sampled at posedge axi_aclk. Outputs are registered and reflect events one cycle later.
- AW handshake pushes awlen+1 into the write length FIFO. AW push into a full FIFO: no push, ERR_OVF.
- W path:
  - wbeat counter counts handshaked beats against the FIFO head. Expected-last = (wbeat+1 == head).
  - Burst closes on wlast or expected-last, whichever comes first. On close: pop head, wbeat=0, wr_bursts++, bpend++.
  - wlast != expected-last on the closing beat: ERR_W_LEN.
  - W beat with the FIFO empty and no same-cycle AW: ERR_W_NO_AW, beat still counted in wr_beats.
  - Same-cycle AW push into an empty FIFO is bypassed, so that beat uses the new length.
- B path: B handshake with bpend==0 gives ERR_B_EARLY; otherwise bpend--. bpend saturates at 2*OUTSTANDING.
- AR path: AR handshake pushes arlen+1 into FIFO[arid]. arid>=ID_NUM gives ERR_BAD_ID (no push). Full FIFO gives ERR_OVF.
- R path:
  - Same close/ERR_R_LEN rules as W, using per-ID rbeat[rid] against FIFO[rid] head.
  - R beat for an empty ID FIFO: ERR_R_NO_AR.
  - rid>=ID_NUM: ERR_BAD_ID.
  - Same-cycle AR and R on the same ID are bypassed as for W.
- Error events:
  - Multiple errors in one cycle set every flag. err_cnt adds the number of distinct errors that cycle, saturating at 16'hFFFF.
  - first_err latches the lowest code among that cycle's errors, and only when err_vec was 0.
- Codes: 0 none, 1 W_LEN, 2 W_NO_AW, 3 B_EARLY, 4 R_LEN, 5 R_NO_AR, 6 OVF, 7 BAD_ID. err_vec[0] is unused, always 0.
- Length arithmetic is LSIZE+1 bits, so awlen=255 gives 256 beats. Beat counters are LSIZE+1 bits.
- Reset mid-burst discards all tracking state without raising errors.

Decomposition:
- axi_chk_pkg: err_code_e (3-bit enum above), ERR_W constant, function len_w(LSIZE) = LSIZE+1.
- Sub-module axi_len_fifo: sync FIFO, width LSIZE+1, depth OUTSTANDING, with push/pop/full/empty/count and head bypass. Instantiated 1 + ID_NUM times.

Test Plan:
- AW len=3, then 4 W beats with wlast on the 4th, then B -> wr_beats=4, wr_bursts=1, err_vec=0, wr_pending returns to 0.
- AW len=3, wlast on beat 2 -> ERR_W_LEN, first_err=1, err_cnt=1. A following correct burst closes cleanly and adds no error.
- AR id1 len=1 and AR id2 len=0, R order id2(last), id1, id1(last) -> rd_bursts=2, no error. Then rid=5 with ID_NUM=4 -> ERR_BAD_ID.
- Five AWs with no W (OUTSTANDING=4) -> ERR_OVF on the 5th, wr_pending=4. B with no W ever completed -> ERR_B_EARLY.
- AW and first W beat in the same cycle with an empty FIFO, awlen=0, wlast=1 -> no error, wr_bursts=1.
- Raise an error, pulse clr in the same cycle as a new error -> all outputs 0 next cycle. Assert axi_aresetn low mid-burst -> outputs 0 immediately, and the next burst checks cleanly.
